// File: rtl/ctrl_cmd_sequencer.sv
// Control-port command sequencer: waits for a settled MMCM lock, debounces the
// start button, then streams a fixed list of 4-bit commands over valid/ready.
module ctrl_cmd_sequencer #(
  parameter int unsigned             DEBOUNCE_CYCLES    = 1250000,
  parameter int unsigned             LOCK_SETTLE_CYCLES = 1024,
  parameter int unsigned             CMD_COUNT          = 4,
  parameter logic [4*CMD_COUNT-1:0]  CMD_SEQ            = 16'h4321
) (
  input  logic       clk_125,
  input  logic       sys_rst,
  input  logic       mmcm_locked_i,
  input  logic       start_config,
  output logic [3:0] control_data,
  output logic       control_valid,
  input  logic       control_ready,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       lock_lost
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SET_W = (LOCK_SETTLE_CYCLES > 1) ? $clog2(LOCK_SETTLE_CYCLES) : 1;
  localparam int unsigned IDX_W = (CMD_COUNT > 1) ? $clog2(CMD_COUNT) : 1;

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_ARMED     = 2'd1;
  localparam logic [1:0] S_SEND      = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic             lock_s1_q, lock_s2_q, start_s1_q, start_s2_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             press_q, press_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lost_q, lost_d;

  function automatic logic [3:0] cmd_at(input logic [IDX_W-1:0] i);
    return 4'(CMD_SEQ >> {i, 2'b00});
  endfunction

  // Debounce: the synced input must differ from the current level for
  // DEBOUNCE_CYCLES consecutive cycles before the level follows it.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (start_s2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_d = start_s2_q;
      db_cnt_d   = '0;
      press_d    = start_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    lost_d   = lost_q;
    if (state_q == S_WAIT_LOCK) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      if (!lock_s2_q) begin
        settle_d = '0;
      end else if (settle_q == SET_W'(LOCK_SETTLE_CYCLES - 1)) begin
        settle_d = '0;
        state_d  = S_ARMED;
      end else begin
        settle_d = settle_q + SET_W'(1);
      end
    end else if (!lock_s2_q) begin
      // Lock loss after arming abandons the sequence; pending press is dropped.
      state_d  = S_WAIT_LOCK;
      settle_d = '0;
      idx_d    = '0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      lost_d   = 1'b1;
    end else if (state_q == S_SEND) begin
      if (valid_q && control_ready) begin
        if (idx_q == IDX_W'(CMD_COUNT - 1)) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          data_d = cmd_at(idx_q + IDX_W'(1));
        end
      end
    end else if (press_q) begin
      state_d = S_SEND;
      idx_d   = '0;
      data_d  = cmd_at('0);
      valid_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
      settle_q   <= '0;
      state_q    <= S_WAIT_LOCK;
      idx_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      lock_s1_q  <= mmcm_locked_i;
      lock_s2_q  <= lock_s1_q;
      start_s1_q <= start_config;
      start_s2_q <= start_s1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
      settle_q   <= settle_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
    end
  end

  assign control_data  = data_q;
  assign control_valid = valid_q;
  assign seq_busy      = busy_q;
  assign seq_done      = done_q;
  assign lock_lost     = lost_q;

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
// Directed bench for ctrl_cmd_sequencer with short debounce/settle times.
module tb_ctrl_cmd_sequencer;

  logic       clk_125 = 1'b0;
  logic       sys_rst;
  logic       mmcm_locked_i;
  logic       start_config;
  logic [3:0] control_data;
  logic       control_valid;
  logic       control_ready;
  logic       seq_busy;
  logic       seq_done;
  logic       lock_lost;

  int checks = 0;
  int errors = 0;

  ctrl_cmd_sequencer #(
    .DEBOUNCE_CYCLES(8),
    .LOCK_SETTLE_CYCLES(4),
    .CMD_COUNT(4),
    .CMD_SEQ(16'hA5C3)
  ) dut (
    .clk_125(clk_125),
    .sys_rst(sys_rst),
    .mmcm_locked_i(mmcm_locked_i),
    .start_config(start_config),
    .control_data(control_data),
    .control_valid(control_valid),
    .control_ready(control_ready),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .lock_lost(lock_lost)
  );

  always #5 clk_125 = ~clk_125;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_125);
      #1;
    end
  endtask

  // Counts cycles until control_valid rises, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!control_valid && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  logic [3:0] exp_seq [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
  logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] pat_data[7] = '{4'h3, 4'hC, 4'hC, 4'hC, 4'h5, 4'h5, 4'hA};

  initial begin
    int n, hs, vcnt, drop;
    sys_rst       = 1'b1;
    mmcm_locked_i = 1'b1;
    start_config  = 1'b0;
    control_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(control_valid), 0);
    check("rst_data", 32'(control_data), 0);
    check("rst_flags", {29'd0, seq_busy, seq_done, lock_lost}, 0);

    // 1a: steady lock arms exactly 2+4 cycles after release
    sys_rst = 1'b0;
    tick(5);
    check("t1_not_armed_e5", 32'(dut.state_q), 0);
    tick(1);
    check("t1_armed_e6", 32'(dut.state_q), 1);

    // 1b: one-cycle bounce restarts the settle count
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    tick(3);
    mmcm_locked_i = 1'b0;
    tick(1);
    mmcm_locked_i = 1'b1;
    tick(5);
    check("t1_bounce_wait_e9", 32'(dut.state_q), 0);
    check("t1_bounce_out", {28'd0, control_valid, seq_busy, seq_done, lock_lost}, 0);
    tick(1);
    check("t1_bounce_armed_e10", 32'(dut.state_q), 1);

    // 2: 20-cycle press, ready held high, back-to-back sequence
    control_ready = 1'b1;
    start_config  = 1'b1;
    tick(10);
    check("t2_no_valid_yet", 32'(control_valid), 0);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_valid%0d", k), 32'(control_valid), 1);
      check($sformatf("t2_data%0d", k), 32'(control_data), 32'(exp_seq[k]));
      tick(1);
    end
    check("t2_valid_off", 32'(control_valid), 0);
    check("t2_done", {30'd0, seq_done, seq_busy}, 32'h2);
    check("t2_data_hold", 32'(control_data), 32'hA);
    tick(5);
    start_config = 1'b0;
    tick(14);

    // 3: short pulses never debounce
    vcnt = 0;
    for (int p = 0; p < 4; p++) begin
      start_config = 1'b1;
      for (int c = 0; c < 5; c++) begin tick(1); vcnt += 32'(control_valid); end
      start_config = 1'b0;
      for (int c = 0; c < 3; c++) begin tick(1); vcnt += 32'(control_valid); end
    end
    for (int c = 0; c < 12; c++) begin tick(1); vcnt += 32'(control_valid); end
    check("t3_valid_cycles", 32'(vcnt), 0);
    check("t3_still_done", 32'(seq_done), 1);

    // 4: ready toggling holds each nibble until accepted
    control_ready = 1'b0;
    start_config  = 1'b1;
    wait_valid(n);
    check("t4_press_lat", 32'(n), 11);
    start_config = 1'b0;
    hs = 0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t4_valid%0d", k), 32'(control_valid), 1);
      check($sformatf("t4_data%0d", k), 32'(control_data), 32'(pat_data[k]));
      control_ready = rdy_pat[k];
      if (control_valid && rdy_pat[k]) begin
        if (hs < 4) check($sformatf("t4_hs%0d", hs), 32'(control_data), 32'(exp_seq[hs]));
        hs++;
      end
      tick(1);
    end
    check("t4_hs_count", 32'(hs), 4);
    check("t4_end", {30'd0, control_valid, seq_done}, 32'h1);
    control_ready = 1'b0;
    tick(12);

    // 5: lock loss after the 2nd handshake, then relock and resend
    control_ready = 1'b1;
    start_config  = 1'b1;
    wait_valid(n);
    check("t5_press_lat", 32'(n), 11);
    start_config = 1'b0;
    tick(2);
    check("t5_data_after2", 32'(control_data), 32'h5);
    control_ready = 1'b0;
    mmcm_locked_i = 1'b0;
    tick(2);
    check("t5_sync_delay", {30'd0, control_valid, lock_lost}, 32'h2);
    tick(1);
    check("t5_abort", {28'd0, control_valid, seq_busy, seq_done, lock_lost}, 32'h1);
    check("t5_data_hold", 32'(control_data), 32'h5);
    mmcm_locked_i = 1'b1;
    control_ready = 1'b1;
    tick(12);
    check("t5_sticky", 32'(lock_lost), 1);
    check("t5_idle", 32'(control_valid), 0);
    start_config = 1'b1;
    wait_valid(n);
    check("t5_relock_lat", 32'(n), 11);
    check("t5_resend_cmd0", 32'(control_data), 32'h3);
    start_config  = 1'b0;
    control_ready = 1'b0;
    tick(1);
    check("t5_sticky2", 32'(lock_lost), 1);

    // 6: async reset mid-send clears outputs without a clock edge
    #3;
    sys_rst = 1'b1;
    #1;
    check("t6_async_out", {27'd0, control_data, control_valid}, 0);
    check("t6_async_flags", {29'd0, seq_busy, seq_done, lock_lost}, 0);
    tick(2);
    sys_rst = 1'b0;
    control_ready = 1'b1;
    drop = 0;
    for (int c = 0; c < 20; c++) begin tick(1); drop += 32'(control_valid); end
    check("t6_no_cmd_without_press", 32'(drop), 0);
    start_config = 1'b1;
    wait_valid(n);
    check("t6_press_lat", 32'(n), 11);
    check("t6_cmd0", 32'(control_data), 32'h3);
    start_config = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
